// File: rtl/downsample.sv
// Streaming box-filter decimator: averages each group of 2^r consecutive
// signed IL.FL samples and emits one mean per group, SIZE/2^r per frame.
// Build option: define DOWNSAMPLE_ROUND_EN to round half toward +inf
// instead of flooring when r > 0.
//
// state | meaning
// IDLE  | waiting for start; no input accepted
// RUN   | accepting samples, producing one output per completed group
// DRAIN | all SIZE samples taken; holding the final output until accepted
module downsample #(
    parameter int IL   = 4,
    parameter int FL   = 16,
    parameter int SIZE = 16,
    parameter int MAXR = $clog2(SIZE),
    parameter int RW   = $clog2(MAXR + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [RW-1:0]        ratio_log2,
    input  logic [IL+FL-1:0]     in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [IL+FL-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done
);

    localparam int W  = IL + FL;
    localparam int AW = W + MAXR;
    localparam int CW = $clog2(SIZE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic signed [AW-1:0]  acc;
    logic [MAXR-1:0]       grp_cnt;
    logic [CW-1:0]         in_cnt;
    logic [RW-1:0]         r_q;

    logic [RW-1:0]         r_clamp;
    logic [MAXR-1:0]       grp_max;
    logic                  grp_last;
    logic                  last_in;
    logic                  xfer;
    logic                  out_acc;
    logic signed [AW-1:0]  in_ext;
    logic signed [AW-1:0]  sum;
    logic signed [AW-1:0]  rnd;
    logic signed [AW-1:0]  sum_rnd;
    logic signed [AW-1:0]  shifted;

    assign r_clamp  = (ratio_log2 > RW'(MAXR)) ? RW'(MAXR) : ratio_log2;
    // 2^r - 1 without a variable-width subtract: r = MAXR shifts every bit out
    assign grp_max  = ~({MAXR{1'b1}} << r_q);
    assign grp_last = (grp_cnt == grp_max);
    assign last_in  = (in_cnt == CW'(SIZE - 1));
    assign xfer     = (state == RUN) && in_valid && in_ready;
    assign out_acc  = out_valid && out_ready;
    assign busy     = (state != IDLE);

    assign in_ext   = {{MAXR{in_data[W-1]}}, in_data};
    assign sum      = acc + in_ext;
`ifdef DOWNSAMPLE_ROUND_EN
    assign rnd      = (r_q == '0) ? '0 : (AW'(1) << (r_q - RW'(1)));
`else
    assign rnd      = '0;
`endif
    assign sum_rnd  = sum + rnd;
    // The mean of W-bit words always fits in W bits, so dropping the top is lossless
    assign shifted  = sum_rnd >>> r_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and input-side handshake
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                in_ready = !out_valid || out_ready;
                if (in_valid && (!out_valid || out_ready) && last_in) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (out_valid && out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Accumulator, counters, output slot and frame-done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            grp_cnt   <= '0;
            in_cnt    <= '0;
            r_q       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= (state == DRAIN) && out_acc;

            if (state == IDLE && start) begin
                r_q     <= r_clamp;
                acc     <= '0;
                grp_cnt <= '0;
                in_cnt  <= '0;
            end else if (xfer) begin
                in_cnt <= in_cnt + 1'b1;
                if (grp_last) begin
                    acc      <= '0;
                    grp_cnt  <= '0;
                    out_data <= shifted[W-1:0];
                end else begin
                    acc     <= sum;
                    grp_cnt <= grp_cnt + 1'b1;
                end
            end

            // A completing group refills the slot even as the old word leaves
            if (xfer && grp_last) begin
                out_valid <= 1'b1;
            end else if (out_acc) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_downsample.sv
// Directed bench for downsample (IL=4, FL=16, SIZE=16).
module tb_downsample;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  ratio_log2;
    logic [19:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;

    downsample #(.IL(4), .FL(16), .SIZE(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ratio_log2 (ratio_log2),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [19:0] samp [16];
    int          stall_lo;
    int          stall_hi;
    int          start_at;
    logic [19:0] outq [$];
    int          out_cyc [$];
    int          in_cyc [$];
    int          done_cnt;
    int          stable_err;
    int          irdy_err;
    int          done_busy_err;
    bit          timeout;

    // Runs one frame: start pulse (with a junk in_valid word alongside),
    // feeds samp[], applies the out_ready stall window, logs handshakes.
    task automatic run_frame(input logic [2:0] ratio);
        int          idx;
        int          cyc;
        int          after_done;
        bit          prev_pend;
        logic [19:0] prev_data;
        outq.delete();
        out_cyc.delete();
        in_cyc.delete();
        done_cnt = 0; stable_err = 0; irdy_err = 0; done_busy_err = 0;
        start = 1'b1; ratio_log2 = ratio; in_valid = 1'b1; in_data = 20'h12345; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; ratio_log2 = 3'd0;
        idx = 0; cyc = 0; after_done = -1; prev_pend = 1'b0; prev_data = '0;
        while (cyc < 200) begin
            if (done === 1'b1) begin
                done_cnt++;
                if (busy !== 1'b0) done_busy_err++;
                if (after_done < 0) after_done = cyc;
            end
            if (prev_pend && out_valid && out_data !== prev_data) stable_err++;
            if (after_done >= 0 && cyc >= after_done + 3) break;
            in_valid  = (idx < 16);
            in_data   = (idx < 16) ? samp[idx] : 20'h0;
            out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
            start     = (cyc == start_at);
            #1;
            if (busy && out_valid && !out_ready && in_ready) irdy_err++;
            if (in_valid && in_ready) begin
                in_cyc.push_back(cyc);
                idx++;
            end
            if (out_valid && out_ready) begin
                outq.push_back(out_data);
                out_cyc.push_back(cyc);
            end
            prev_pend = out_valid && !out_ready;
            prev_data = out_data;
            @(posedge clk); #1;
            cyc++;
        end
        timeout   = (after_done < 0);
        in_valid  = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset;
        int acc_n;
        int cyc;
        n_cmp++;
        if (out_data !== 20'h0 || out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_init: out_data=%h out_valid=%b in_ready=%b busy=%b done=%b, required all 0",
                     out_data, out_valid, in_ready, busy, done);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; ratio_log2 = 3'd1;
        @(posedge clk); #1;
        start = 1'b0;
        acc_n = 0; cyc = 0; out_ready = 1'b1;
        while (acc_n < 5 && cyc < 20) begin
            in_valid = 1'b1; in_data = 20'h0A000;
            #1;
            if (in_ready) acc_n++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (acc_n !== 5) begin
            n_bad++;
            $display("FAIL reset_prefill: accepted %0d inputs, required 5", acc_n);
        end
        n_cmp++;
        if (busy !== 1'b1 || out_data !== 20'h0A000) begin
            n_bad++;
            $display("FAIL reset_premid: busy=%b out_data=%h, required busy=1 out_data=0a000", busy, out_data);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (out_data !== 20'h0 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_async_out: out_data=%h out_valid=%b, required 0/0", out_data, out_valid);
        end
        n_cmp++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_async_ctl: busy=%b in_ready=%b done=%b, required 0/0/0", busy, in_ready, done);
        end
        @(posedge clk); #3 rst = 1'b0;
        @(posedge clk); #1;
        // Fresh r=1 frame: pair means of k*0x1000 are (4j+1)*0x800
        for (int k = 0; k < 16; k++) samp[k] = 20'(k * 32'h1000);
        stall_lo = -10; stall_hi = -10; start_at = -1;
        run_frame(3'd1);
        n_cmp++;
        if (timeout || outq.size() != 8) begin
            n_bad++;
            $display("FAIL after_reset_count: outputs=%0d timeout=%b, required 8 outputs", outq.size(), timeout);
        end
        for (int j = 0; j < 8 && j < outq.size(); j++) begin
            n_cmp++;
            if (outq[j] !== 20'((4 * j + 1) * 32'h800)) begin
                n_bad++;
                $display("FAIL after_reset_val[%0d]: got %h, required %h", j, outq[j], 20'((4 * j + 1) * 32'h800));
            end
        end
        n_cmp++;
        if (done_cnt != 1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL after_reset_done: done pulses=%0d busy=%b, required 1 pulse and busy=0", done_cnt, busy);
        end
    endtask

    task automatic test_mean_r2;
        for (int k = 0; k < 16; k++) samp[k] = 20'(((k % 4) + 1) * 32'h10000);
        stall_lo = -10; stall_hi = -10; start_at = -1;
        run_frame(3'd2);
        n_cmp++;
        if (timeout || outq.size() != 4) begin
            n_bad++;
            $display("FAIL r2_count: outputs=%0d timeout=%b, required 4", outq.size(), timeout);
        end
        for (int j = 0; j < 4 && j < outq.size(); j++) begin
            n_cmp++;
            if (outq[j] !== 20'h28000) begin
                n_bad++;
                $display("FAIL r2_val[%0d]: got %h, required 28000", j, outq[j]);
            end
            if (in_cyc.size() > 4 * j + 3) begin
                n_cmp++;
                if (out_cyc[j] != in_cyc[4 * j + 3] + 1) begin
                    n_bad++;
                    $display("FAIL r2_latency[%0d]: output cycle %0d, required %0d", j, out_cyc[j], in_cyc[4 * j + 3] + 1);
                end
            end
        end
        n_cmp++;
        if (done_cnt != 1 || done_busy_err != 0) begin
            n_bad++;
            $display("FAIL r2_done: pulses=%0d done_while_busy=%0d, required 1 and 0", done_cnt, done_busy_err);
        end
    endtask

    task automatic test_negative_round;
        logic [19:0] exp_v;
`ifdef DOWNSAMPLE_ROUND_EN
        exp_v = 20'h00000;
`else
        exp_v = 20'hFFFFF;
`endif
        for (int k = 0; k < 16; k++) samp[k] = (k % 2 == 0) ? 20'hFFFFF : 20'h00000;
        stall_lo = -10; stall_hi = -10; start_at = -1;
        run_frame(3'd1);
        n_cmp++;
        if (timeout || outq.size() != 8) begin
            n_bad++;
            $display("FAIL neg_count: outputs=%0d timeout=%b, required 8", outq.size(), timeout);
        end
        for (int j = 0; j < 8 && j < outq.size(); j++) begin
            n_cmp++;
            if (outq[j] !== exp_v) begin
                n_bad++;
                $display("FAIL neg_val[%0d]: got %h, required %h", j, outq[j], exp_v);
            end
        end
    endtask

    task automatic test_backpressure;
        for (int k = 0; k < 16; k++) samp[k] = 20'(32'hF0000 - k * 32'h101);
        stall_lo = 5; stall_hi = 7; start_at = -1;
        run_frame(3'd0);
        n_cmp++;
        if (timeout || outq.size() != 16) begin
            n_bad++;
            $display("FAIL bp_count: outputs=%0d timeout=%b, required 16", outq.size(), timeout);
        end
        for (int j = 0; j < 16 && j < outq.size(); j++) begin
            n_cmp++;
            if (outq[j] !== samp[j]) begin
                n_bad++;
                $display("FAIL bp_val[%0d]: got %h, required %h", j, outq[j], samp[j]);
            end
        end
        n_cmp++;
        if (stable_err != 0 || irdy_err != 0) begin
            n_bad++;
            $display("FAIL bp_hold: data changes while stalled=%0d in_ready while pending=%0d, required 0/0",
                     stable_err, irdy_err);
        end
        n_cmp++;
        if (done_cnt != 1) begin
            n_bad++;
            $display("FAIL bp_done: pulses=%0d, required 1", done_cnt);
        end
    endtask

    task automatic test_back_to_back;
        for (int k = 0; k < 16; k++) samp[k] = 20'(32'h80000 + k * 32'h3001);
        stall_lo = -10; stall_hi = -10; start_at = -1;
        run_frame(3'd0);
        n_cmp++;
        if (timeout || outq.size() != 16 || in_cyc.size() != 16) begin
            n_bad++;
            $display("FAIL b2b_count: outputs=%0d inputs=%0d timeout=%b, required 16/16", outq.size(), in_cyc.size(), timeout);
        end else begin
            n_cmp++;
            if (in_cyc[15] - in_cyc[0] != 15) begin
                n_bad++;
                $display("FAIL b2b_rate: 16 inputs spanned %0d cycles, required 15", in_cyc[15] - in_cyc[0]);
            end
            for (int j = 0; j < 16; j++) begin
                n_cmp++;
                if (outq[j] !== samp[j] || out_cyc[j] != in_cyc[j] + 1) begin
                    n_bad++;
                    $display("FAIL b2b_val[%0d]: got %h at cycle %0d, required %h at cycle %0d",
                             j, outq[j], out_cyc[j], samp[j], in_cyc[j] + 1);
                end
            end
        end
    endtask

    task automatic test_clamp_ignored_start;
        // ratio 7 clamps to 4: mean of k*0x1000, k=0..15, is 0x7800
        for (int k = 0; k < 16; k++) samp[k] = 20'(k * 32'h1000);
        stall_lo = -10; stall_hi = -10; start_at = 3;
        run_frame(3'd7);
        n_cmp++;
        if (timeout || outq.size() != 1) begin
            n_bad++;
            $display("FAIL clamp_count: outputs=%0d timeout=%b, required 1", outq.size(), timeout);
        end else begin
            n_cmp++;
            if (outq[0] !== 20'h07800) begin
                n_bad++;
                $display("FAIL clamp_val: got %h, required 07800", outq[0]);
            end
        end
        n_cmp++;
        if (done_cnt != 1) begin
            n_bad++;
            $display("FAIL clamp_done: pulses=%0d, required 1", done_cnt);
        end
    endtask

    task automatic test_full_scale;
        for (int k = 0; k < 16; k++) samp[k] = (k < 8) ? 20'h7FFFF : 20'h80000;
        stall_lo = -10; stall_hi = -10; start_at = -1;
        run_frame(3'd3);
        n_cmp++;
        if (timeout || outq.size() != 2) begin
            n_bad++;
            $display("FAIL fs_count: outputs=%0d timeout=%b, required 2", outq.size(), timeout);
        end else begin
            n_cmp++;
            if (outq[0] !== 20'h7FFFF) begin
                n_bad++;
                $display("FAIL fs_max: got %h, required 7ffff", outq[0]);
            end
            n_cmp++;
            if (outq[1] !== 20'h80000) begin
                n_bad++;
                $display("FAIL fs_min: got %h, required 80000", outq[1]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ratio_log2 = 3'd0;
        in_data = 20'h0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_mean_r2();
        test_negative_round();
        test_backpressure();
        test_back_to_back();
        test_clamp_ignored_start();
        test_full_scale();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/downsample.md
Name: downsample

Overview:
- Streaming decimator, the inverse of the interpolating upsampler in the same fixed-point datapath (IL.FL signed).
- Consumes one frame of SIZE input samples and emits SIZE/2^r outputs. Each output is the mean of 2^r consecutive inputs (box filter followed by decimation).
- Sits between attention/feature stages that need a reduced sequence length.
- Valid/ready handshake on both sides; start/done frame control.

Parameters:
- IL, 4, integer bits of the fixed-point word
- FL, 16, fractional bits of the fixed-point word
- SIZE, 16, input samples per frame (power of two, >=2)
- MAXR, $clog2(SIZE), maximum log2 decimation ratio
- RW, $clog2(MAXR+1), width of ratio_log2

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- start  input  1  one-cycle pulse; begins a frame and latches ratio_log2
- ratio_log2  input  RW  log2 of the decimation ratio r; sampled only on accepted start
- in_data  input  IL+FL  signed input sample
- in_valid  input  1  in_data valid
- in_ready  output  1  block accepts in_data this cycle
- out_data  output  IL+FL  signed averaged sample
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts out_data
- busy  output  1  frame in progress (state != IDLE)
- done  output  1  one-cycle pulse when the last output of the frame is accepted

Behaviour:
- Reset (async, any time, including mid-frame): state=IDLE; accumulator, sample counters and out_data = 0; out_valid, in_ready, busy, done = 0. The partial frame is discarded.
- Word width W=IL+FL. The accumulator is W+MAXR bits, signed, and sign-extends each input.
- Ratio latching on start in IDLE: r = min(ratio_log2, MAXR).
- start in any other state is ignored.
- States:
  - IDLE: in_ready=0. start -> RUN; accumulator, in_cnt and grp_cnt cleared.
  - RUN: in_ready = !out_valid || out_ready. A transfer occurs when in_valid && in_ready.
    - Each transfer adds in_data to the accumulator and increments grp_cnt.
    - When grp_cnt reaches 2^r-1 on a transfer:
      - out_data <= (acc + in_data) >>> r (arithmetic shift; floor). If the output slot still holds a pending word, it is being consumed in the same cycle.
      - out_valid <= 1 the next cycle.
      - Accumulator and grp_cnt cleared.
    - Latency: the output is registered and valid 1 cycle after the 2^r-th input of a group is accepted.
    - Throughput: 1 input/cycle while out_ready=1. With r=0, each output equals its input delayed 1 cycle.
    - When the SIZE-th input of the frame is accepted -> DRAIN.
  - DRAIN: in_ready=0. Hold out_valid/out_data until out_ready. On acceptance: out_valid <= 0, done=1 for exactly one cycle, -> IDLE.
- Output handshake:
  - out_data is stable while out_valid && !out_ready.
  - out_valid clears on acceptance unless a new group completes in the same cycle. In that case it stays 1 with new data; back-to-back operation has no bubble.
- Overflow: a mean of W-bit values always fits in W bits, so truncation of the shifted result to W bits is lossless.
- Simultaneous start and in_valid in IDLE: that in_data is not consumed (in_ready=0 in IDLE).
- in_valid outside RUN: ignored.
- busy = (state != IDLE). done is asserted in IDLE only on the cycle immediately after the DRAIN handshake.

Optional Feature:
- Macro DOWNSAMPLE_ROUND_EN.
- When defined: for r>0, 2^(r-1) is added to the sum before the shift (round half toward +inf). Result stays in range: max mean + 1/2, floored, is the max word. For r=0, the result is unchanged.
- When undefined: pure arithmetic-shift truncation (floor).
- The handshake, latency and state machine are identical in both builds.

Test Plan:
- Reset/idle: assert rst mid-RUN after 5 inputs -> all outputs 0 immediately (async). Then start with r=1 and feed 16 samples -> 8 outputs; no residue from the aborted frame.
- r=2, SIZE=16, inputs 1.0,2.0,3.0,4.0 repeated, out_ready=1 -> 4 outputs, each 2.5 (0x28000 at FL=16). Each appears 1 cycle after its 4th input. done pulses once after the 4th output.
- Negative floor vs round, r=1, inputs -1 LSB and 0:
  - without DOWNSAMPLE_ROUND_EN -> out = -1 LSB (0xFFFFF)
  - with it -> out = 0
- Backpressure: r=0, hold out_ready=0 for 3 cycles mid-frame -> in_ready=0 while out_valid pending. out_data stable; no samples lost or duplicated; 16 outputs equal the 16 inputs in order.
- Clamp/ignored start: ratio_log2=7 with SIZE=16 -> r=4, 1 output equal to the mean of 16 inputs. A start pulse during RUN is ignored and the frame completes normally.
- Full-scale: r=3, eight inputs of 0x7FFFF -> out 0x7FFFF. Eight inputs of 0x80000 -> out 0x80000. Same results in both builds.
